// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier and adder back-end stages.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_NORMAL = 2'b00,
        FP_ZERO   = 2'b01,
        FP_INF    = 2'b10,
        FP_NAN    = 2'b11
    } fp_special_e;

    localparam int          FP32_BIAS    = 127;
    localparam int          FP32_EXP_MAX = 255;
    localparam logic [31:0] FP32_QNAN    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_DENORM,
        ST_ROUND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp_mul_norm_round_if.sv
// Upstream product / downstream result handshake bundle for the normalise-round stage.
interface fp_mul_norm_round_if #(parameter int EXP_W = 10);

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic signed [EXP_W-1:0] in_exp;
    logic [47:0]             in_mant;
    logic [1:0]              in_special;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_result;
    logic [2:0]              out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a 24-bit significand plus guard/sticky; yields the packed
// exponent/fraction field. Shared with the adder back-end.
module fp_round_rne #(
    parameter int EXP_W = 10
) (
    input  logic [24:0]             mant_in,   // {bit46, frac[22:0], guard}
    input  logic                    sticky_in,
    input  logic signed [EXP_W-1:0] exp_in,
    output logic [30:0]             field,
    output logic                    carry,
    output logic                    inexact
);

    logic [23:0]             sig;
    logic                    guard;
    logic                    inc;
    logic [24:0]             sum;
    logic                    lead;
    logic signed [EXP_W-1:0] exp_r;
    logic [7:0]              exp_field;

    always_comb begin
        sig   = mant_in[24:1];
        guard = mant_in[0];
        inc   = guard & (sticky_in | sig[0]);
        sum   = {1'b0, sig} + {24'd0, inc};
        carry = sum[24];
        lead  = carry | sum[23];
        exp_r = carry ? exp_in + EXP_W'(1) : exp_in;
        // A subnormal that rounds up sets bit46 and thereby becomes the smallest normal.
        exp_field = (exp_r == EXP_W'(1) && !lead) ? 8'h00 : exp_r[7:0];
        field     = {exp_field, carry ? 23'd0 : sum[22:0]};
        inexact   = guard | sticky_in;
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Iterative normalise / denormalise / RNE-round back-end for the single-precision multiplier.
module fp_mul_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W      = 10,
    parameter int DENORM_CUT = 26
) (
    input  logic                clk,
    input  logic                rst,
    fp_mul_norm_round_if.slave  bus
);

    localparam logic signed [EXP_W-1:0] EXP_ONE    = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] DENORM_LIM = EXP_W'(1 - DENORM_CUT);
    localparam logic signed [EXP_W-1:0] EXP_OVF    = EXP_W'(FP32_EXP_MAX);

    state_e                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [47:0]             mant_q, mant_d;
    logic                    sticky_q, sticky_d;
    logic [31:0]             result_q, result_d;
    logic [2:0]              flags_q, flags_d;

    logic [30:0]             rnd_field;
    logic                    rnd_carry;
    logic                    rnd_inexact;
    logic signed [EXP_W-1:0] exp_rnd;

    fp_round_rne #(.EXP_W(EXP_W)) u_round (
        .mant_in   (mant_q[46:22]),
        .sticky_in (sticky_q | (|mant_q[21:0])),
        .exp_in    (exp_q),
        .field     (rnd_field),
        .carry     (rnd_carry),
        .inexact   (rnd_inexact)
    );

    assign exp_rnd = rnd_carry ? exp_q + EXP_ONE : exp_q;

    // NOTE: every *_d gets its *_q value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        sticky_d = sticky_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.in_sign;
                    exp_d    = bus.in_exp;
                    mant_d   = bus.in_mant;
                    sticky_d = 1'b0;
                    flags_d  = 3'b000;
                    state_d  = ST_DONE;
                    case (fp_special_e'(bus.in_special))
                        FP_ZERO: result_d = {bus.in_sign, 31'd0};
                        FP_INF:  result_d = {bus.in_sign, 8'hFF, 23'd0};
                        FP_NAN:  result_d = FP32_QNAN;
                        default: state_d  = ST_NORM;
                    endcase
                end
            end
            ST_NORM: begin
                if (mant_q == 48'd0) begin
                    result_d = {sign_q, 31'd0};
                    flags_d  = 3'b000;
                    state_d  = ST_DONE;
                end else if (mant_q[47]) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + EXP_ONE;
                end else if (!mant_q[46] && exp_q > EXP_ONE) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end else if (exp_q < EXP_ONE) begin
                    state_d = ST_DENORM;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_DENORM: begin
                // Far below the subnormal range everything collapses into sticky at once.
                if (exp_q < DENORM_LIM) begin
                    sticky_d = sticky_q | (|mant_q);
                    mant_d   = 48'd0;
                    exp_d    = EXP_ONE;
                    state_d  = ST_ROUND;
                end else begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + EXP_ONE;
                    if (exp_q + EXP_ONE == EXP_ONE) state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (exp_rnd >= EXP_OVF) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    flags_d  = 3'b101;
                end else begin
                    result_d = {sign_q, rnd_field};
                    flags_d  = {1'b0, rnd_inexact && (rnd_field[30:23] == 8'h00), rnd_inexact};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= 48'd0;
            sticky_q <= 1'b0;
            result_q <= 32'd0;
            flags_q  <= 3'b000;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign bus.out_flags  = flags_q;

endmodule
